// File: rtl/mem_access_sequencer.sv
// MEM-stage data-memory sequencer: checks alignment, runs one bus cycle per
// access, extracts/zero-extends loads and aborts stalled cycles on timeout.
module mem_access_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_enable,
  input  logic        mem_RW,
  input  logic [1:0]  mem_size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        err,
  output logic        err_code
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  logic [1:0]  state;
  logic        rw_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic [7:0]  cnt;
  logic        aligned;
  logic        timeout;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [31:0] load_data;

  always_comb begin
    aligned = 1'b1;
    be_n    = 4'b1111;
    wdata_n = wdata;
    case (mem_size)
      2'b00: begin
        be_n    = 4'b0001 << addr[1:0];
        wdata_n = {4{wdata[7:0]}};
      end
      2'b01: begin
        aligned = ~addr[0];
        be_n    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{wdata[15:0]}};
      end
      default: aligned = (addr[1:0] == 2'b00);
    endcase
  end

  // Load extraction uses the size/offset latched at acceptance, not live inputs.
  always_comb begin
    load_data = bus_rdata;
    case (size_q)
      2'b00:   load_data = {24'd0, bus_rdata[8*off_q +: 8]};
      2'b01:   load_data = {16'd0, off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0]};
      default: load_data = bus_rdata;
    endcase
  end

  assign timeout = (cnt == 8'(TIMEOUT - 1));
  assign stall   = rst_n & (((state == IDLE) & mem_enable) | (state == BUSY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rw_q        <= 1'b0;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
      cnt         <= 8'd0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= 32'd0;
      bus_wdata   <= 32'd0;
      bus_be      <= 4'd0;
      rdata       <= 32'd0;
      rdata_valid <= 1'b0;
      err         <= 1'b0;
      err_code    <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      err         <= 1'b0;
      case (state)
        IDLE: if (mem_enable) begin
          if (aligned) begin
            state     <= BUSY;
            rw_q      <= mem_RW;
            size_q    <= mem_size;
            off_q     <= addr[1:0];
            cnt       <= 8'd0;
            bus_req   <= 1'b1;
            bus_we    <= mem_RW;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_wdata <= wdata_n;
            bus_be    <= be_n;
          end else begin
            state    <= ERR;
            err      <= 1'b1;
            err_code <= 1'b0;
          end
        end
        BUSY: begin
          // A late ack still completes the access even on the timeout cycle.
          if (bus_ack) begin
            state   <= DONE;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            if (!rw_q) begin
              rdata       <= load_data;
              rdata_valid <= 1'b1;
            end
          end else if (timeout) begin
            state    <= ERR;
            bus_req  <= 1'b0;
            bus_we   <= 1'b0;
            err      <= 1'b1;
            err_code <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer: each access is driven until the
// pipeline releases, and observed bus/result values are compared to hand values.
module tb_mem_access_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_enable = 1'b0;
  logic        mem_RW = 1'b0;
  logic [1:0]  mem_size = 2'b00;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'd0;
  logic        stall, bus_req, bus_we, rdata_valid, err, err_code;
  logic [31:0] bus_addr, bus_wdata, rdata;
  logic [3:0]  bus_be;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_sequencer #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .mem_enable(mem_enable), .mem_RW(mem_RW),
    .mem_size(mem_size), .addr(addr), .wdata(wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .stall(stall), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be), .rdata(rdata),
    .rdata_valid(rdata_valid), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Observed results of the last access
  int          o_stall, o_busy, o_vcyc, o_vcnt;
  logic        o_req, o_err, o_errc, o_we, o_end;
  logic [31:0] o_rdata, o_baddr, o_bwdata;
  logic [3:0]  o_be;

  // ack_cyc: BUSY cycle (1-based) in which bus_ack is driven; 0 = never.
  task automatic access(input logic rw, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int ack_cyc);
    o_stall = 0; o_busy = 0; o_vcyc = -1; o_vcnt = 0;
    o_req = 0; o_err = 0; o_errc = 0; o_we = 0; o_end = 0;
    o_rdata = 0; o_baddr = 0; o_bwdata = 0; o_be = 0;
    @(negedge clk);
    mem_enable = 1'b1; mem_RW = rw; mem_size = sz; addr = a; wdata = wd;
    for (int c = 0; c < 60 && !o_end; c++) begin
      #1;
      if (stall) o_stall++;
      if (rdata_valid) begin o_vcnt++; o_vcyc = c; o_rdata = rdata; end
      if (err) begin o_err = 1; o_errc = err_code; end
      if (bus_req) begin
        o_req = 1; o_busy++;
        o_baddr = bus_addr; o_bwdata = bus_wdata; o_be = bus_be; o_we = bus_we;
        bus_ack = (o_busy == ack_cyc);
        bus_rdata = bus_ack ? rd : 32'h0BAD_0BAD;
      end else begin
        bus_ack = 1'b0;
      end
      // Stall low after the first cycle means the instruction retires now;
      // mem_enable stays high through this DONE/ERR cycle and must be ignored.
      if (!stall && c > 0) o_end = 1;
      @(negedge clk);
    end
    mem_enable = 1'b0; bus_ack = 1'b0;
    chk("access_terminated", 32'(o_end), 32'd1);
    #1;
    chk("post_valid_low", 32'(rdata_valid), 32'd0);
    chk("post_err_low", 32'(err), 32'd0);
    chk("post_req_low", 32'(bus_req), 32'd0);
  endtask

  initial begin
    // Reset state, with mem_enable asserted to confirm stall stays low.
    mem_enable = 1'b1;
    #12;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_be", 32'(bus_be), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_flags", {28'd0, rdata_valid, err, err_code, bus_we}, 32'd0);
    mem_enable = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Minimum latency word load
    access(1'b0, 2'b10, 32'h0000_0040, 32'd0, 32'h1357_9BDF, 1);
    chk("min_stall", 32'(o_stall), 32'd2);
    chk("min_vcyc", 32'(o_vcyc), 32'd2);
    chk("min_rdata", o_rdata, 32'h1357_9BDF);

    // Word load, ack on third BUSY cycle
    access(1'b0, 2'b10, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 3);
    chk("wl_stall", 32'(o_stall), 32'd4);
    chk("wl_rdata", o_rdata, 32'hDEAD_BEEF);
    chk("wl_vcnt", 32'(o_vcnt), 32'd1);
    chk("wl_addr", o_baddr, 32'h0000_0100);
    chk("wl_be", 32'(o_be), 32'hF);
    chk("wl_we", 32'(o_we), 32'd0);

    // Byte store
    access(1'b1, 2'b00, 32'h0000_0203, 32'h0000_005A, 32'hFFFF_FFFF, 2);
    chk("bs_be", 32'(o_be), 32'b1000);
    chk("bs_wdata", o_bwdata, 32'h5A5A_5A5A);
    chk("bs_addr", o_baddr, 32'h0000_0200);
    chk("bs_we", 32'(o_we), 32'd1);
    chk("bs_novalid", 32'(o_vcnt), 32'd0);

    // Halfword store, upper half
    access(1'b1, 2'b01, 32'h0000_0102, 32'h1234_BEEF, 32'd0, 1);
    chk("hs_be", 32'(o_be), 32'b1100);
    chk("hs_wdata", o_bwdata, 32'hBEEF_BEEF);

    // Halfword load, upper half
    access(1'b0, 2'b01, 32'h0000_0012, 32'd0, 32'hABCD_1234, 1);
    chk("hl_rdata", o_rdata, 32'h0000_ABCD);
    chk("hl_be", 32'(o_be), 32'b1100);

    // Byte load lane 1
    access(1'b0, 2'b00, 32'h0000_0101, 32'd0, 32'h1122_3344, 2);
    chk("bl_rdata", o_rdata, 32'h0000_0033);
    chk("bl_be", 32'(o_be), 32'b0010);

    // Size 11 treated as word
    access(1'b0, 2'b11, 32'h0000_0008, 32'd0, 32'h8765_4321, 1);
    chk("s3_rdata", o_rdata, 32'h8765_4321);

    // Misaligned word load
    access(1'b0, 2'b10, 32'h0000_0101, 32'd0, 32'd0, 1);
    chk("mis_err", 32'(o_err), 32'd1);
    chk("mis_code", 32'(o_errc), 32'd0);
    chk("mis_noreq", 32'(o_req), 32'd0);
    chk("mis_stall", 32'(o_stall), 32'd1);

    // Misaligned halfword
    access(1'b0, 2'b01, 32'h0000_0013, 32'd0, 32'd0, 1);
    chk("mish_err", 32'(o_err), 32'd1);
    chk("mish_noreq", 32'(o_req), 32'd0);

    // Timeout
    access(1'b0, 2'b10, 32'h0000_0300, 32'd0, 32'd0, 0);
    chk("to_err", 32'(o_err), 32'd1);
    chk("to_code", 32'(o_errc), 32'd1);
    chk("to_busy", 32'(o_busy), 32'd16);
    chk("to_novalid", 32'(o_vcnt), 32'd0);

    // Ack on the timeout cycle wins
    access(1'b0, 2'b10, 32'h0000_0304, 32'd0, 32'hCAFE_F00D, 16);
    chk("race_err", 32'(o_err), 32'd0);
    chk("race_rdata", o_rdata, 32'hCAFE_F00D);

    // bus_ack while idle is ignored
    @(negedge clk); bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
    repeat (3) @(negedge clk);
    #1;
    chk("idle_ack_req", 32'(bus_req), 32'd0);
    chk("idle_ack_valid", 32'(rdata_valid), 32'd0);
    chk("idle_ack_rdata", rdata, 32'hCAFE_F00D);
    bus_ack = 1'b0;

    // Reset mid-BUSY
    @(negedge clk);
    mem_enable = 1'b1; mem_RW = 1'b0; mem_size = 2'b10; addr = 32'h0000_0400;
    @(negedge clk); @(negedge clk);
    chk("mid_req_before", 32'(bus_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_req_async", 32'(bus_req), 32'd0);
    chk("mid_stall", 32'(stall), 32'd0);
    chk("mid_flags", {30'd0, rdata_valid, err}, 32'd0);
    @(negedge clk);
    mem_enable = 1'b0;
    rst_n = 1'b1;
    access(1'b0, 2'b10, 32'h0000_0404, 32'd0, 32'h0F0F_1234, 2);
    chk("after_rst_rdata", o_rdata, 32'h0F0F_1234);
    chk("after_rst_stall", 32'(o_stall), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
